// File: rtl/serial_comparator.sv
// Bit-serial MSB-first magnitude comparator with early termination.
// Operands are latched on an accepted start; one bit position is examined per clock.
module serial_comparator #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g2,
  output logic             l2,
  output logic             e2,
  output logic [CW-1:0]    bits_cmp
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    CMP
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q, done_q, g2_q, l2_q, e2_q;
  logic [CW-1:0]    bits_q;

  logic             a_bit, b_bit, at_msb, at_lsb;
  logic [CW-1:0]    k_d;

  // k is the 1-based scan position counted from the MSB.
  always_comb begin
    a_bit  = a_q[idx_q];
    b_bit  = b_q[idx_q];
    at_msb = (idx_q == IW'(WIDTH - 1));
    at_lsb = (idx_q == '0);
    k_d    = CW'(WIDTH) - CW'(idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      g2_q    <= 1'b0;
      l2_q    <= 1'b0;
      e2_q    <= 1'b0;
      bits_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sm_q    <= signed_mode;
            idx_q   <= IW'(WIDTH - 1);
            busy_q  <= 1'b1;
            g2_q    <= 1'b0;
            l2_q    <= 1'b0;
            e2_q    <= 1'b0;
            bits_q  <= '0;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (a_bit != b_bit) begin
            // A set sign bit means the smaller value in two's complement.
            if (sm_q && at_msb) begin
              g2_q <= ~a_bit;
              l2_q <= a_bit;
            end else begin
              g2_q <= a_bit;
              l2_q <= ~a_bit;
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            bits_q  <= k_d;
            state_q <= IDLE;
          end else if (at_lsb) begin
            e2_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            bits_q  <= CW'(WIDTH);
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign g2       = g2_q;
  assign l2       = l2_q;
  assign e2       = e2_q;
  assign bits_cmp = bits_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed self-checking bench for serial_comparator at WIDTH=8 and WIDTH=2.
module tb_serial_comparator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, sm8, busy8, done8, g8, l8, e8;
  logic [7:0] a8, b8;
  logic [3:0] bits8;

  logic       start2, sm2, busy2, done2, g2w, l2w, e2w;
  logic [1:0] a2, b2;
  logic [1:0] bits2;

  int n_cmp = 0;
  int n_bad = 0;

  serial_comparator #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .g2(g8), .l2(l8), .e2(e8), .bits_cmp(bits8)
  );

  serial_comparator #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .g2(g2w), .l2(l2w), .e2(e2w), .bits_cmp(bits2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic sm, input logic eg, input logic el, input logic ee,
                      input int ek);
    int n;
    a8 = av; b8 = bv; sm8 = sm; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk({tag, ".busy_acc"}, busy8, 1);
    chk({tag, ".done_acc"}, done8, 0);
    n = 0;
    do begin
      tick();
      n++;
      if (!done8) chk({tag, ".busy_mid"}, busy8, 1);
    end while (!done8 && n < 12);
    chk({tag, ".latency"}, n, ek);
    chk({tag, ".g2"}, g8, eg);
    chk({tag, ".l2"}, l8, el);
    chk({tag, ".e2"}, e8, ee);
    chk({tag, ".bits"}, bits8, ek);
    chk({tag, ".busy_done"}, busy8, 0);
    tick();
    chk({tag, ".done_pulse"}, done8, 0);
    chk({tag, ".hold_g2"}, g8, eg);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
    tick();
    tick();
    chk("rst.busy", busy8, 0);
    chk("rst.done", done8, 0);
    chk("rst.flags", {g8, l8, e8}, 3'b000);
    chk("rst.bits", bits8, 0);
    rst = 1'b0;
    tick();
    chk("rst_rel.flags", {busy8, done8, g8, l8, e8}, 5'b00000);

    run8("eqA5", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    run8("u80_7F", 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    run8("s80_7F", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    run8("u12_13", 8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 8);
    run8("uF0_E0", 8'hF0, 8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    run8("sFF_01", 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    run8("sFE_FF", 8'hFE, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8);
    run8("s00_FF", 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1);

    // Handshake: ignored start while busy, then back-to-back start in the done cycle.
    a8 = 8'h40; b8 = 8'h00; sm8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("hs.busy_e1", busy8, 1);
    tick();
    chk("hs.done_e2", done8, 1);
    chk("hs.g2_e2", g8, 1);
    chk("hs.bits_e2", bits8, 2);
    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("hs.b2b_busy", busy8, 1);
    chk("hs.b2b_done", done8, 0);
    chk("hs.b2b_g2clr", g8, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done8 && n < 12);
    chk("hs.b2b_latency", n, 7);
    chk("hs.b2b_l2", l8, 1);
    chk("hs.b2b_g2", g8, 0);
    chk("hs.b2b_bits", bits8, 7);
    tick();

    // Reset abort mid-compare.
    a8 = 8'h00; b8 = 8'h01; sm8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    chk("abort.busy_pre", busy8, 1);
    rst = 1'b1;
    #1;
    chk("abort.outs_now", {busy8, done8, g8, l8, e8}, 5'b00000);
    chk("abort.bits_now", bits8, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort.no_done", done8, 0);
    end
    rst = 1'b0;
    tick();
    chk("abort.idle", {busy8, done8, g8, l8, e8}, 5'b00000);
    run8("after_abort", 8'h33, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8);

    // WIDTH=2 sweep against an integer reference model.
    for (int m = 0; m < 2; m++) begin
      for (int ai = 0; ai < 4; ai++) begin
        for (int bi = 0; bi < 4; bi++) begin
          int va, vb, ek;
          logic [1:0] ta, tb;
          ta = ai[1:0];
          tb = bi[1:0];
          va = (m == 1 && ta[1]) ? ai - 4 : ai;
          vb = (m == 1 && tb[1]) ? bi - 4 : bi;
          ek = (ta[1] != tb[1]) ? 1 : 2;
          a2 = ta; b2 = tb; sm2 = m[0]; start2 = 1'b1;
          tick();
          start2 = 1'b0;
          n = 0;
          do begin
            tick();
            n++;
          end while (!done2 && n < 5);
          chk($sformatf("w2.m%0d.a%0d.b%0d.lat", m, ai, bi), n, ek);
          chk($sformatf("w2.m%0d.a%0d.b%0d.gle", m, ai, bi), {g2w, l2w, e2w},
              {va > vb, va < vb, va == vb});
          chk($sformatf("w2.m%0d.a%0d.b%0d.bits", m, ai, bi), bits2, ek);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
